// File: rtl/write_back_stage_pkg.sv
// Shared types for the write-back stage: result-source and load-size encodings.
package wb_pkg;

   // Result source selected by the MEM stage.
   typedef enum logic [1:0] {
      SEL_ALU  = 2'd0,
      SEL_LOAD = 2'd1,
      SEL_LINK = 2'd2,
      SEL_IMM  = 2'd3
   } wb_sel_e;

   // Load access size; encoding 3 is treated as a word as well.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } wb_size_e;

   // Entries held between the MEM stage and the register file.
   localparam int WB_SKID_DEPTH = 2;

endpackage : wb_pkg

// File: rtl/write_back_stage_if.sv
// Bundle of MEM-side handshake, register-file write port, forwarding tap and retire count.
interface write_back_stage_if
   import wb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   // MEM stage -> write-back
   logic              mem_valid;
   logic              mem_ready;
   logic [1:0]        mem_sel;
   logic [DATA_W-1:0] mem_alu;
   logic [DATA_W-1:0] mem_load;
   logic [DATA_W-1:0] mem_link;
   logic [DATA_W-1:0] mem_imm;
   logic [1:0]        mem_size;
   logic              mem_signed;
   logic [1:0]        mem_off;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_we;
   // write-back -> register file
   logic              rf_we;
   logic [REG_AW-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              rf_ready;
   // forwarding tap and retire statistics
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  retire_cnt;

   // The surrounding pipeline / bench side
   modport master (
      output mem_valid, mem_sel, mem_alu, mem_load, mem_link, mem_imm,
             mem_size, mem_signed, mem_off, mem_rd, mem_we, rf_ready,
      input  mem_ready, rf_we, rf_addr, rf_data, fwd_valid, fwd_rd, fwd_data,
             retire_cnt
   );

   // The write-back stage itself
   modport slave (
      input  mem_valid, mem_sel, mem_alu, mem_load, mem_link, mem_imm,
             mem_size, mem_signed, mem_off, mem_rd, mem_we, rf_ready,
      output mem_ready, rf_we, rf_addr, rf_data, fwd_valid, fwd_rd, fwd_data,
             retire_cnt
   );
endinterface : write_back_stage_if

// File: rtl/write_back_stage_skid_buffer.sv
// Small in-order buffer: head always at slot 0, occupancy counter, flush drops everything.
module wb_skid_buffer
   import wb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] ent_q [DEPTH];
   logic [WIDTH-1:0] ent_d [DEPTH];
   logic             push, pop;
   logic [CW-1:0]    wr_idx;

   // Ready depends only on registered occupancy and flush, never on out_ready_i.
   assign in_ready_o  = (cnt_q < CW'(DEPTH)) && !flush_i;
   assign out_valid_o = (cnt_q != '0);
   assign out_data_o  = ent_q[0];
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   // A same-cycle pop shifts the queue down, so the new entry lands one slot lower.
   assign wr_idx      = cnt_q - CW'(pop);

   // Next-state: shift on pop, write tail on push, flush empties the buffer.
   always_comb begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
         ent_d[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (CW'(i) == wr_idx)) ent_d[i] = in_data_i;
      end
      if (flush_i) cnt_d = '0;
   end

   // State registers; reset clears contents so the head reads zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

endmodule : wb_skid_buffer

// File: rtl/write_back_stage.sv
// Write-back stage: result select + load extension ahead of a 2-entry skid buffer,
// register-file write port, forwarding tap and retire counter.
module write_back_stage
   import wb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input logic               Clk,
   input logic               Rst_n,
   input logic               Flush,
   write_back_stage_if.slave wb
);
   localparam int         EW       = REG_AW + DATA_W;
   // Byte offset bits that exist for this width (0, 1 or 2 bits).
   localparam logic [1:0] OFF_MASK = 2'((DATA_W / 8) - 1);

   logic [1:0]        off_b;
   logic              half_sel;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] result;
   logic              enq_valid;
   logic              buf_ready;
   logic              buf_valid;
   logic [EW-1:0]     head;
   logic              deq;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Extract the addressed byte/half from the load word and extend it to DATA_W.
   always_comb begin
      off_b    = wb.mem_off & OFF_MASK;
      // Halves only exist at offset 2 on a 32-bit datapath.
      half_sel = (DATA_W == 32) ? wb.mem_off[1] : 1'b0;
      byte_v   = 8'(wb.mem_load >> {off_b, 3'b000});
      half_v   = 16'(wb.mem_load >> {half_sel, 4'b0000});
      load_ext = wb.mem_load;
      case (wb.mem_size)
         SZ_BYTE: load_ext = wb.mem_signed ? DATA_W'($signed(byte_v)) : DATA_W'(byte_v);
         SZ_HALF: begin
            // An 8-bit datapath has no half: pass the word through.
            if (DATA_W > 8)
               load_ext = wb.mem_signed ? DATA_W'($signed(half_v)) : DATA_W'(half_v);
         end
         default: load_ext = wb.mem_load;
      endcase
   end

   // Pick the result source for the instruction on the MEM side.
   always_comb begin
      result = wb.mem_alu;
      case (wb.mem_sel)
         SEL_ALU:  result = wb.mem_alu;
         SEL_LOAD: result = load_ext;
         SEL_LINK: result = wb.mem_link;
         SEL_IMM:  result = wb.mem_imm;
         default:  result = wb.mem_alu;
      endcase
   end

   // Non-writing instructions and writes to r0 are consumed but never buffered.
   assign enq_valid = wb.mem_valid && wb.mem_we && (wb.mem_rd != '0);

   wb_skid_buffer #(
      .WIDTH (EW),
      .DEPTH (WB_SKID_DEPTH)
   ) u_skid (
      .clk_i       (Clk),
      .rst_ni      (Rst_n),
      .flush_i     (Flush),
      .in_valid_i  (enq_valid),
      .in_ready_o  (buf_ready),
      .in_data_i   ({wb.mem_rd, result}),
      .out_valid_o (buf_valid),
      .out_ready_i (wb.rf_ready),
      .out_data_o  (head)
   );

   assign wb.mem_ready = buf_ready;
   assign wb.rf_we     = buf_valid;
   assign wb.rf_addr   = head[EW-1:DATA_W];
   assign wb.rf_data   = head[DATA_W-1:0];
   assign wb.fwd_valid = buf_valid;
   assign wb.fwd_rd    = head[EW-1:DATA_W];
   assign wb.fwd_data  = head[DATA_W-1:0];
   assign deq          = buf_valid && wb.rf_ready;

   // Count each completed write, including one that coincides with a flush.
   always_comb begin
      cnt_d = cnt_q;
      if (deq) cnt_d = cnt_q + 1'b1;
   end

   // Retire counter register; only reset clears it.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign wb.retire_cnt = cnt_q;

endmodule : write_back_stage

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage against a queue-based reference model.
module tb_write_back_stage;
   localparam int DW = 32;
   localparam int AW = 3;
   localparam int CW = 4;

   logic Clk = 1'b0;
   logic Rst_n;
   logic Flush;

   write_back_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) wb ();

   write_back_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Flush (Flush),
      .wb    (wb)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t mq[$];
   int   mcnt;
   int   n_run, n_fail;

   // Reference result: plain arithmetic on the selected source.
   function automatic logic [DW-1:0] ref_result();
      logic [31:0] v;
      case (wb.mem_sel)
         2'd0: v = wb.mem_alu;
         2'd2: v = wb.mem_link;
         2'd3: v = wb.mem_imm;
         default: begin
            if (wb.mem_size == 2'd0) begin
               v = (wb.mem_load >> (8 * wb.mem_off)) & 32'hFF;
               if (wb.mem_signed && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (wb.mem_size == 2'd1) begin
               v = (wb.mem_load >> (16 * (wb.mem_off / 2))) & 32'hFFFF;
               if (wb.mem_signed && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
               v = wb.mem_load;
            end
         end
      endcase
      return v;
   endfunction

   // Advance one clock edge and move the model along with it.
   task automatic tick();
      bit   acc, pop, fl;
      ent_t e;
      acc    = wb.mem_valid && (mq.size() < 2) && !Flush;
      pop    = (mq.size() != 0) && wb.rf_ready;
      fl     = Flush;
      e.rd   = wb.mem_rd;
      e.data = ref_result();
      @(posedge Clk);
      if (pop) begin
         void'(mq.pop_front());
         mcnt = (mcnt + 1) % 16;
      end
      if (fl) mq.delete();
      else if (acc && wb.mem_we && wb.mem_rd != 0) mq.push_back(e);
      #1;
   endtask

   task automatic idle_inputs();
      wb.mem_valid = 0; wb.mem_sel = 0; wb.mem_alu = 0; wb.mem_load = 0;
      wb.mem_link = 0; wb.mem_imm = 0; wb.mem_size = 0; wb.mem_signed = 0;
      wb.mem_off = 0; wb.mem_rd = 0; wb.mem_we = 0; wb.rf_ready = 0;
      Flush = 0;
   endtask

   task automatic randomize_fields();
      wb.mem_sel    = 2'($urandom_range(0, 3));
      wb.mem_alu    = $urandom;
      wb.mem_load   = $urandom;
      wb.mem_link   = $urandom;
      wb.mem_imm    = $urandom;
      wb.mem_size   = 2'($urandom_range(0, 3));
      wb.mem_signed = 1'($urandom_range(0, 1));
      wb.mem_off    = 2'($urandom_range(0, 3));
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      mq.delete();
      mcnt = 0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      Rst_n = 1'b1;
      #1 Rst_n = 1'b0;
      mq.delete(); mcnt = 0;
      @(posedge Clk); @(posedge Clk); #1;
      n_run++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", wb.rf_we); end
      n_run++; if (wb.rf_addr !== '0 || wb.rf_data !== '0) begin n_fail++; $display("FAIL reset_rf_bus: got %h/%h want 0/0", wb.rf_addr, wb.rf_data); end
      n_run++; if (wb.fwd_valid !== 1'b0 || wb.fwd_rd !== '0 || wb.fwd_data !== '0) begin n_fail++; $display("FAIL reset_fwd: got %b/%h/%h want 0", wb.fwd_valid, wb.fwd_rd, wb.fwd_data); end
      n_run++; if (wb.retire_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", wb.retire_cnt); end
      Rst_n = 1'b1;
      tick();
      n_run++; if (wb.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wb.mem_ready); end
   endtask

   task automatic test_load_ext();
      wb.rf_ready = 1; wb.mem_valid = 1; wb.mem_we = 1; wb.mem_rd = 5;
      wb.mem_sel = 2'd1; wb.mem_load = 32'h1234_80FF; wb.mem_size = 2'd0;
      wb.mem_off = 2'd1; wb.mem_signed = 1;
      tick();
      n_run++; if (wb.rf_we !== 1'b1 || wb.rf_addr !== 3'd5 || wb.rf_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL load_signed: got %b/%0d/%h want 1/5/ffffff80", wb.rf_we, wb.rf_addr, wb.rf_data); end
      wb.mem_signed = 0;
      tick();
      n_run++; if (wb.rf_data !== 32'h0000_0080) begin n_fail++; $display("FAIL load_unsigned: got %h want 00000080", wb.rf_data); end
      for (int i = 0; i < 40; i++) begin
         randomize_fields();
         wb.mem_rd = 3'($urandom_range(1, 7));
         tick();
         n_run++; if (mq.size() == 0 || wb.rf_we !== 1'b1 || wb.rf_addr !== mq[0].rd || wb.rf_data !== mq[0].data) begin
            n_fail++; $display("FAIL select_rand: got %b/%0d/%h want head %0d/%h", wb.rf_we, wb.rf_addr, wb.rf_data, (mq.size() != 0) ? mq[0].rd : 3'd0, (mq.size() != 0) ? mq[0].data : 32'd0);
         end
         n_run++; if (wb.fwd_valid !== wb.rf_we || wb.fwd_rd !== mq[0].rd || wb.fwd_data !== mq[0].data) begin n_fail++; $display("FAIL fwd_tap: got %b/%0d/%h", wb.fwd_valid, wb.fwd_rd, wb.fwd_data); end
      end
      wb.mem_valid = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      int start;
      wb.mem_valid = 0; wb.rf_ready = 1;
      tick(); tick();
      start = mcnt;
      wb.rf_ready = 0; wb.mem_valid = 1; wb.mem_we = 1; wb.mem_sel = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         wb.mem_rd = 3'(k); wb.mem_alu = 32'(k * 32'h1111);
         n_run++; if (wb.mem_ready !== (k < 3)) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", k, wb.mem_ready, k < 3); end
         tick();
      end
      n_run++; if (wb.rf_addr !== 3'd1 || wb.rf_data !== 32'h1111) begin n_fail++; $display("FAIL bp_hold: got %0d/%h want 1/1111", wb.rf_addr, wb.rf_data); end
      wb.rf_ready = 1;
      n_run++; if (wb.mem_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_comb_ready: got %b want 0", wb.mem_ready); end
      tick();
      n_run++; if (wb.rf_addr !== 3'd2 || wb.mem_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second: got rd %0d ready %b want 2/1", wb.rf_addr, wb.mem_ready); end
      tick();
      wb.mem_valid = 0;
      n_run++; if (wb.rf_addr !== 3'd3 || wb.rf_data !== 32'h3333) begin n_fail++; $display("FAIL bp_third: got %0d/%h want 3/3333", wb.rf_addr, wb.rf_data); end
      tick();
      n_run++; if (wb.rf_we !== 1'b0 || int'(wb.retire_cnt) != (start + 3) % 16) begin n_fail++; $display("FAIL bp_drain: got we %b cnt %0d want 0/%0d", wb.rf_we, wb.retire_cnt, (start + 3) % 16); end
   endtask

   task automatic test_drop();
      logic [CW-1:0] saved;
      saved = wb.retire_cnt;
      wb.rf_ready = 1; wb.mem_valid = 1; wb.mem_we = 0; wb.mem_rd = 3'd4;
      n_run++; if (wb.mem_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b want 1", wb.mem_ready); end
      tick();
      n_run++; if (wb.rf_we !== 1'b0) begin n_fail++; $display("FAIL drop_we0: got rf_we %b want 0", wb.rf_we); end
      wb.mem_we = 1; wb.mem_rd = 3'd0;
      tick();
      wb.mem_valid = 0;
      tick();
      n_run++; if (wb.rf_we !== 1'b0 || wb.retire_cnt !== saved) begin n_fail++; $display("FAIL drop_rd0: got we %b cnt %0d want 0/%0d", wb.rf_we, wb.retire_cnt, saved); end
   endtask

   task automatic test_flush();
      logic [CW-1:0] saved;
      wb.rf_ready = 0; wb.mem_valid = 1; wb.mem_we = 1; wb.mem_sel = 2'd3;
      wb.mem_rd = 3'd6; wb.mem_imm = 32'hAAAA; tick();
      wb.mem_rd = 3'd7; wb.mem_imm = 32'hBBBB; tick();
      wb.mem_valid = 0;
      saved = wb.retire_cnt;
      Flush = 1; wb.rf_ready = 1;
      #1;
      n_run++; if (wb.mem_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", wb.mem_ready); end
      tick();
      Flush = 0;
      #1;
      n_run++; if (wb.rf_we !== 1'b0 || wb.retire_cnt !== CW'(saved + 1)) begin n_fail++; $display("FAIL flush_empty: got we %b cnt %0d want 0/%0d", wb.rf_we, wb.retire_cnt, CW'(saved + 1)); end
      n_run++; if (wb.mem_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %b want 1", wb.mem_ready); end
   endtask

   task automatic test_wrap();
      idle_inputs();
      do_reset();
      wb.rf_ready = 1; wb.mem_valid = 1; wb.mem_we = 1; wb.mem_rd = 3'd1;
      for (int i = 0; i < 17; i++) begin
         wb.mem_alu = $urandom;
         tick();
      end
      wb.mem_valid = 0;
      tick();
      n_run++; if (wb.retire_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", wb.retire_cnt); end
   endtask

   task automatic test_async_reset();
      wb.rf_ready = 0; wb.mem_valid = 1; wb.mem_we = 1; wb.mem_sel = 2'd0;
      wb.mem_rd = 3'd2; tick();
      wb.mem_rd = 3'd3; tick();
      wb.mem_valid = 0;
      n_run++; if (wb.rf_we !== 1'b1 || wb.retire_cnt !== 4'd1) begin n_fail++; $display("FAIL areset_pre: got we %b cnt %0d want 1/1", wb.rf_we, wb.retire_cnt); end
      #2 Rst_n = 1'b0;
      mq.delete(); mcnt = 0;
      #1;
      n_run++; if (wb.rf_we !== 1'b0 || wb.retire_cnt !== '0 || wb.rf_data !== '0) begin n_fail++; $display("FAIL areset_now: got we %b cnt %0d data %h want 0/0/0", wb.rf_we, wb.retire_cnt, wb.rf_data); end
      @(posedge Clk); #1;
      Rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         randomize_fields();
         wb.mem_valid = 1'($urandom_range(0, 3) != 0);
         wb.mem_we    = 1'($urandom_range(0, 7) != 0);
         wb.mem_rd    = 3'($urandom_range(0, 7));
         wb.rf_ready  = 1'($urandom_range(0, 1));
         Flush        = ($urandom_range(0, 15) == 0);
         #1;
         n_run++; if (wb.mem_ready !== ((mq.size() < 2) && !Flush)) begin n_fail++; $display("FAIL rand_ready@%0d: got %b occ %0d", i, wb.mem_ready, mq.size()); end
         tick();
         n_run++; if (wb.rf_we !== (mq.size() != 0) || (mq.size() != 0 && (wb.rf_addr !== mq[0].rd || wb.rf_data !== mq[0].data))) begin
            n_fail++; $display("FAIL rand_head@%0d: got %b/%0d/%h occ %0d", i, wb.rf_we, wb.rf_addr, wb.rf_data, mq.size());
         end
         n_run++; if (int'(wb.retire_cnt) != mcnt) begin n_fail++; $display("FAIL rand_cnt@%0d: got %0d want %0d", i, wb.retire_cnt, mcnt); end
      end
      Flush = 0;
   endtask

   initial begin
      n_run = 0; n_fail = 0; mcnt = 0;
      test_reset();
      test_load_ext();
      test_back_to_back();
      test_drop();
      test_flush();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule : tb_write_back_stage

// File: doc/write_back_stage.md
# write_back_stage

Parametrised successor to the processor's single-register write-back stage. It accepts completed instructions from the data-memory stage over a valid/ready handshake and selects the result source (ALU, load, link, immediate). It sign- or zero-extends sub-word loads and buffers up to two results in a skid buffer while the register file is busy. It also presents the head result for forwarding and counts retired register writes.

## Interface
Parameters:
- DATA_W, 8: datapath width; legal values 8, 16, 32.
- REG_AW, 3: register address width.
- CNT_W, 16: retire counter width.

Ports:
- Clk  in  1  stage clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous; discards all buffered results.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage can accept this cycle.
- mem_sel  in  2  result source: 0 ALU, 1 LOAD, 2 LINK, 3 IMM.
- mem_alu, mem_load, mem_link, mem_imm  in  DATA_W each  candidate results.
- mem_size  in  2  load size: 0 byte, 1 half, 2/3 word.
- mem_signed  in  1  sign-extend sub-word load.
- mem_off  in  2  byte offset of the load within the word; bits beyond clog2(DATA_W/8) are ignored.
- mem_rd  in  REG_AW  destination register.
- mem_we  in  1  instruction writes a register.
- rf_we  out  1  head result valid for the register file.
- rf_addr  out  REG_AW  head destination.
- rf_data  out  DATA_W  head data.
- rf_ready  in  1  register file accepts the write this cycle.
- fwd_valid, fwd_rd, fwd_data  out  1/REG_AW/DATA_W  head entry, same as rf_* (forwarding tap).
- retire_cnt  out  CNT_W  count of completed register writes.

## Operation
- Accept: mem_valid && mem_ready.
- Accepted instructions with mem_we=0 or mem_rd=0 are consumed and dropped. They are not enqueued and not counted.
- Result select by mem_sel. For LOAD, extract a byte or half at mem_off, then extend to DATA_W using mem_signed.
  - Half offset uses mem_off[1] only.
  - When DATA_W=8, half and word pass the input through unchanged.
  - When DATA_W=16, word equals half at offset 0.
- Skid buffer: 2 entries of {rd, data}, FIFO order, occupancy 0..2.
- mem_ready = (occupancy < 2) && !Flush.
- Dequeue: rf_we && rf_ready. retire_cnt increments by 1 on each dequeue and wraps modulo 2^CNT_W.
- rf_we = occupancy != 0. rf_addr/rf_data show the oldest entry.
- Same-cycle enqueue and dequeue: occupancy unchanged, order preserved.
- Flush: occupancy goes to 0 at the next edge. Any dequeue in the same cycle still counts. retire_cnt is not cleared.
- rf_addr/rf_data hold their value while rf_we=1 and rf_ready=0.

## Timing
- Reset (async assert, synchronous deassert release): occupancy 0, rf_we 0, rf_addr 0, rf_data 0, fwd_* 0, retire_cnt 0. mem_ready is 1 one cycle after release.
- Latency: an instruction accepted at edge N is on rf_* from edge N (registered) if the buffer was empty. It is written at the first edge where rf_ready=1.
- Throughput: 1 per cycle with rf_ready held high. With rf_ready held low, exactly two instructions are accepted, then mem_ready=0.
- mem_ready depends only on registered occupancy and Flush; there is no combinational path from rf_ready.
- Reset mid-operation drops all buffered entries immediately.

## Structure
- Package wb_pkg: enum for mem_sel (SEL_ALU, SEL_LOAD, SEL_LINK, SEL_IMM) and enum for mem_size (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module wb_skid_buffer (parameters WIDTH, DEPTH=2): handles occupancy, order, Flush and the valid/ready logic.
- Result selection and load extension remain combinational logic in write_back_stage, ahead of the buffer.

## Test plan
- DATA_W=32, LOAD, mem_load=0x1234_80FF, mem_size=byte, mem_off=1, signed -> rf_data=0xFFFF_FF80. Same with unsigned -> 0x0000_0080.
- rf_ready=0, three back-to-back valid writes to rd 1, 2, 3 -> mem_ready drops after two accepts. Releasing rf_ready -> writes to rd 1 then 2 on consecutive cycles; rd 3 is accepted once space frees.
- mem_rd=0 or mem_we=0 with mem_valid=1 -> accepted, rf_we stays 0, retire_cnt unchanged.
- Occupancy 2, Flush=1 for one cycle with rf_ready=1 -> one write counted, occupancy 0 next cycle, mem_ready=0 during Flush.
- CNT_W=4, 17 writes -> retire_cnt=1 (wrap).
- Rst_n pulsed low with 2 entries buffered -> rf_we=0 and retire_cnt=0 immediately, without a clock edge.
